// File: rtl/pkt_rr_arb.sv
// Round-robin packet arbiter: merges NUM_REQ packet streams onto one output stream.
// Ownership changes only at packet boundaries. Output SOPs are spaced at least
// MIN_SOP_GAP cycles apart. Delimiter violations are counted in a saturating counter.
module pkt_rr_arb #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MIN_SOP_GAP   = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_sop,
    input  logic [NUM_REQ-1:0]            in_eop,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic                          out_valid,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          err_pulse,
    output logic [ERR_CNT_WIDTH-1:0]      err_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(MIN_SOP_GAP + 1);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               gap_ok;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    logic                  fwd;
    logic                  fwd_sop;
    logic                  fwd_eop;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  err_now;

    assign gap_ok = (gap_q == GAP_W'(MIN_SOP_GAP));

    // Round-robin search for the first SOP-ready requester above the last winner.
    always_comb begin
        int idx;
        logic [IDX_W-1:0] sel;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        sel       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            sel = IDX_W'(idx);
            if (!win_found && gap_ok && in_valid[sel] && in_sop[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    // State register: FSM state, round-robin pointer, owner, SOP spacing counter, grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            gap_q   <= GAP_W'(MIN_SOP_GAP);
            grant   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            gap_q   <= gap_d;
            grant   <= grant_d;
        end
    end

    // Next-state logic: start a packet on a win, finish it on an accepted EOP.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        grant_d = '0;
        gap_d   = gap_ok ? gap_q : gap_q + GAP_W'(1);
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    rr_d             = win_idx;
                    owner_d          = win_idx;
                    gap_d            = GAP_W'(1);
                    grant_d[win_idx] = 1'b1;
                    state_d          = in_eop[win_idx] ? IDLE : PKT;
                end
            end
            PKT: begin
                grant_d[owner_q] = 1'b1;
                if (in_valid[owner_q] && in_eop[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready per requester, the beat to forward, and protocol errors.
    always_comb begin
        in_ready = '0;
        fwd      = 1'b0;
        fwd_sop  = 1'b0;
        fwd_eop  = 1'b0;
        fwd_data = '0;
        err_now  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (in_valid[i] && !in_sop[i]) begin
                            in_ready[i] = 1'b1;
                            err_now     = 1'b1;
                        end
                    end
                    if (win_found) begin
                        in_ready[win_idx] = 1'b1;
                        fwd               = 1'b1;
                        fwd_sop           = 1'b1;
                        fwd_eop           = in_eop[win_idx];
                        fwd_data          = in_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                PKT: begin
                    in_ready[owner_q] = 1'b1;
                    if (in_valid[owner_q]) begin
                        fwd      = 1'b1;
                        fwd_eop  = in_eop[owner_q];
                        fwd_data = in_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
                        if (in_sop[owner_q]) begin
                            err_now = 1'b1;
                        end
                    end else begin
                        err_now = 1'b1;
                    end
                end
                default: begin
                    in_ready = '0;
                end
            endcase
        end
    end

    // Registered output stream plus error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            out_valid <= fwd;
            out_sop   <= fwd_sop;
            out_eop   <= fwd_eop;
            out_data  <= fwd_data;
            err_pulse <= err_now;
            if (err_now && (err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Testbench for pkt_rr_arb: per-requester beat queues feed the DUT, a behavioural
// model predicts accepted beats, and a monitor checks the output stream via a scoreboard.
module tb_pkt_rr_arb;

    localparam int NUM_REQ       = 4;
    localparam int DATA_WIDTH    = 8;
    localparam int MIN_SOP_GAP   = 8;
    localparam int ERR_CNT_WIDTH = 16;
    localparam int ERR_MAX       = (1 << ERR_CNT_WIDTH) - 1;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_sop;
    logic [NUM_REQ-1:0]            in_eop;
    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_sop;
    logic                          out_eop;
    logic                          out_valid;
    logic [NUM_REQ-1:0]            grant;
    logic                          err_pulse;
    logic [ERR_CNT_WIDTH-1:0]      err_cnt;

    pkt_rr_arb #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DATA_WIDTH),
        .MIN_SOP_GAP  (MIN_SOP_GAP),
        .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_valid(out_valid),
        .grant    (grant),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        bit                    sop;
        bit                    eop;
        int                    dly;
    } beat_t;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        bit                    sop;
        bit                    eop;
        int                    cyc;
    } exp_t;

    beat_t srcq [NUM_REQ][$];
    exp_t  expq [$];

    int checks = 0;
    int errors = 0;
    int cyc_tb = 0;
    bit mon_en = 1'b0;

    int               m_owner;
    int               m_rr;
    int               m_last_sop;
    int               m_cyc;
    int               m_err;
    int               m_acc;
    bit               m_pulse;
    logic [NUM_REQ-1:0] m_grant;

    // Count rising edges so expected beats can carry their appearance cycle.
    always @(posedge clk) cyc_tb++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc_tb);
        end
    endtask

    task automatic pushExp(input logic [DATA_WIDTH-1:0] d, input bit s, input bit e);
        exp_t x;
        x.data = d;
        x.sop  = s;
        x.eop  = e;
        x.cyc  = cyc_tb + 1;
        expq.push_back(x);
    endtask

    // Scoreboard monitor: every output beat must match the oldest expected beat on time.
    always @(negedge clk) begin
        if (mon_en) begin
            while (expq.size() > 0 && expq[0].cyc < cyc_tb) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_beat actual=none required=%0h due cycle %0d", expq[0].data, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (out_valid) begin
                if (expq.size() > 0 && expq[0].cyc == cyc_tb) begin
                    exp_t x;
                    x = expq.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(x.data));
                    checkOutput("out_sop", 32'(out_sop), 32'(x.sop));
                    checkOutput("out_eop", 32'(out_eop), 32'(x.eop));
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat actual=%0h required=no beat at cycle %0d", out_data, cyc_tb);
                end
            end else begin
                checkOutput("idle_sop", 32'(out_sop), 32'd0);
                checkOutput("idle_eop", 32'(out_eop), 32'd0);
            end
        end
    end

    task automatic modelReset();
        m_owner    = -1;
        m_rr       = NUM_REQ - 1;
        m_last_sop = m_cyc - MIN_SOP_GAP;
        m_err      = 0;
        m_pulse    = 1'b0;
        m_grant    = '0;
    endtask

    // One cycle: check registered outputs, drive source heads, predict and check acceptance.
    task automatic applyStimulus(input bit do_rst);
        logic [NUM_REQ-1:0]            v, s, e, rdy, g;
        logic [NUM_REQ*DATA_WIDTH-1:0] d;
        bit                            pulse;
        int                            o, w, j;
        @(negedge clk);
        checkOutput("grant", 32'(grant), 32'(m_grant));
        checkOutput("err_cnt", 32'(err_cnt), 32'(m_err));
        checkOutput("err_pulse", 32'(err_pulse), 32'(m_pulse));
        v = '0;
        s = '0;
        e = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
            s[i] = 1'($urandom);
            e[i] = 1'($urandom);
            if (srcq[i].size() > 0) begin
                if (srcq[i][0].dly > 0) begin
                    srcq[i][0].dly = srcq[i][0].dly - 1;
                end else begin
                    v[i] = 1'b1;
                    s[i] = srcq[i][0].sop;
                    e[i] = srcq[i][0].eop;
                    d[i*DATA_WIDTH +: DATA_WIDTH] = srcq[i][0].data;
                end
            end
        end
        rst      = do_rst;
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        #1;
        rdy   = '0;
        g     = '0;
        pulse = 1'b0;
        o     = m_owner;
        if (do_rst) begin
            modelReset();
        end else if (o < 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (v[i] && !s[i]) begin
                    rdy[i] = 1'b1;
                    pulse  = 1'b1;
                end
            end
            if (m_cyc - m_last_sop >= MIN_SOP_GAP) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_rr + k) % NUM_REQ;
                    if (w < 0 && v[j] && s[j]) w = j;
                end
                if (w >= 0) begin
                    rdy[w] = 1'b1;
                    g[w]   = 1'b1;
                    pushExp(d[w*DATA_WIDTH +: DATA_WIDTH], 1'b1, e[w]);
                    m_rr       = w;
                    m_last_sop = m_cyc;
                    if (!e[w]) m_owner = w;
                    m_acc++;
                end
            end
        end else begin
            rdy[o] = 1'b1;
            g[o]   = 1'b1;
            if (v[o]) begin
                pushExp(d[o*DATA_WIDTH +: DATA_WIDTH], 1'b0, e[o]);
                if (s[o]) pulse = 1'b1;
                if (e[o]) m_owner = -1;
                m_acc++;
            end else begin
                pulse = 1'b1;
            end
        end
        if (!do_rst) begin
            if (pulse && m_err < ERR_MAX) m_err++;
            m_pulse = pulse;
            m_grant = g;
        end
        checkOutput("in_ready", 32'(in_ready), 32'(rdy));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy[i] && v[i]) void'(srcq[i].pop_front());
        end
        m_cyc++;
    endtask

    task automatic addPacket(input int req, input int len, input int first, input int bub_at,
                             input int bub_len, input int sop_at);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DATA_WIDTH'(first + k);
            b.sop  = (k == 0) || (k == sop_at);
            b.eop  = (k == len - 1);
            b.dly  = (k == bub_at) ? bub_len : 0;
            srcq[req].push_back(b);
        end
    endtask

    task automatic addOrphan(input int req, input int data, input int dly);
        beat_t b;
        b.data = DATA_WIDTH'(data);
        b.sop  = 1'b0;
        b.eop  = 1'b0;
        b.dly  = dly;
        srcq[req].push_back(b);
    endtask

    function automatic bit busy();
        bit r;
        r = (m_owner >= 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (srcq[i].size() > 0) r = 1'b1;
        end
        return r;
    endfunction

    task automatic runUntilEmpty(input int max_cycles, input string name);
        int n;
        n = 0;
        while (busy() && n < max_cycles) begin
            applyStimulus(1'b0);
            n++;
        end
        if (busy()) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_%s actual=busy after %0d cycles required=drained", name, n);
            for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
        end
        repeat (MIN_SOP_GAP + 2) applyStimulus(1'b0);
    endtask

    task automatic runUntilAccepted(input int target, input int max_cycles);
        int n;
        n = 0;
        while (m_acc < target && n < max_cycles) begin
            applyStimulus(1'b0);
            n++;
        end
        if (m_acc < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_accept actual=%0d required=%0d", m_acc, target);
        end
    endtask

    // Main sequence: directed scenarios followed by randomized traffic.
    initial begin
        int n_pk;
        rst      = 1'b1;
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        in_data  = '0;
        m_cyc    = 0;
        m_acc    = 0;
        modelReset();
        m_last_sop = -100;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        $display("[TB] reset state check");
        applyStimulus(1'b1);

        $display("[TB] single 10-beat packet from requester 0");
        addPacket(0, 10, 1, -1, 0, -1);
        runUntilEmpty(100, "single");

        $display("[TB] all requesters with 8-beat packets");
        addPacket(0, 8, 8'h10, -1, 0, -1);
        addPacket(1, 8, 8'h20, -1, 0, -1);
        addPacket(2, 8, 8'h30, -1, 0, -1);
        addPacket(3, 8, 8'h40, -1, 0, -1);
        addPacket(0, 8, 8'h50, -1, 0, -1);
        runUntilEmpty(200, "rr");

        $display("[TB] single-beat packets from requesters 1 and 2");
        addPacket(1, 1, 8'h61, -1, 0, -1);
        addPacket(2, 1, 8'h62, -1, 0, -1);
        runUntilEmpty(100, "onebeat");

        $display("[TB] orphan beat from requester 3");
        addOrphan(3, 8'h77, 0);
        runUntilEmpty(20, "orphan");

        $display("[TB] mid-packet bubble from requester 0");
        addPacket(0, 6, 8'h80, 3, 2, -1);
        runUntilEmpty(100, "bubble");

        $display("[TB] mid-packet SOP from requester 2");
        addPacket(2, 6, 8'h90, -1, 0, 3);
        runUntilEmpty(100, "midsop");

        $display("[TB] reset during a packet");
        n_pk = m_acc;
        addPacket(0, 10, 8'hA0, -1, 0, -1);
        runUntilAccepted(n_pk + 3, 50);
        applyStimulus(1'b1);
        for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
        addPacket(0, 4, 8'hB0, -1, 0, -1);
        runUntilEmpty(100, "postrst");

        $display("[TB] randomized traffic");
        for (int it = 0; it < 60; it++) begin
            int req, len, bat;
            req = $urandom_range(0, NUM_REQ - 1);
            if ($urandom_range(0, 9) == 0) begin
                addOrphan(req, $urandom, $urandom_range(0, 3));
            end else begin
                len = $urandom_range(1, 6);
                bat = 0;
                if (len > 1 && $urandom_range(0, 4) == 0) bat = $urandom_range(1, len - 1);
                addPacket(req, len, $urandom, bat, (bat == 0) ? $urandom_range(0, 3) : $urandom_range(1, 2), -1);
            end
            repeat ($urandom_range(0, 6)) applyStimulus(1'b0);
        end
        runUntilEmpty(3000, "random");

        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
